// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM state encoding for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width: ceil(log2(w)), never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used for all serial bit arithmetic.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one result bit per clock, LSB first,
// through a single full adder. Subtract is a + ~b + 1.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             fa_sum;
    logic             fa_carry;
    logic             cnt_at_last;

    assign cnt_at_last = (cnt == CNT_LAST);
    assign sum         = sum_r;
    assign cout        = cout_r;

    full_adder u_fa (
        .a     (opa[0]),
        .b     (opb[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_at_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, serial shift datapath, bit counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= op_sub ? ~b : b;
                        carry <= op_sub ? 1'b1 : cin;
                        sum_r <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    sum_r <= {fa_sum, sum_r[WIDTH-1:1]};
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= fa_carry;
                    if (cnt_at_last) begin
                        cout_r <= fa_carry;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op_sub  input  1  0 = a+b+cin, 1 = a-b; captured with start.
REQ-006 SHALL have port a  input  WIDTH  first operand; captured with start.
REQ-007 SHALL have port b  input  WIDTH  second operand; captured with start.
REQ-008 SHALL have port cin  input  1  carry-in for add; captured with start; ignored when op_sub=1.
REQ-009 SHALL have port busy  output  1  high in SHIFT state.
REQ-010 SHALL have port done  output  1  one-cycle pulse, high in DONE state.
REQ-011 SHALL have port sum  output  WIDTH  result; valid from done until the next accepted start.
REQ-012 SHALL have port cout  output  1  final carry (add) / no-borrow flag (sub: 1 = a>=b).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL, in IDLE with start=1 at a clock edge: load opA<=a, opB<=(op_sub ? ~b : b), carry<=(op_sub ? 1 : cin), clear sum register, bit counter<=0, go to SHIFT.
REQ-015 SHALL, on each SHIFT edge: compute one bit from opA[0], opB[0], carry through one full adder; shift the sum bit into sum MSB (right shift); shift opA and opB right one place; carry<=adder carry; counter<=counter+1.
REQ-016 SHALL leave SHIFT for DONE on the edge where counter==WIDTH-1; the final carry SHALL be loaded into cout on that edge.
REQ-017 SHALL spend exactly WIDTH cycles in SHIFT; done SHALL be high in the cycle after the WIDTH-th SHIFT edge, i.e. WIDTH+1 cycles after the start-capture edge.
REQ-018 SHALL go from DONE to IDLE unconditionally on the next edge; done high exactly one cycle.
REQ-019 SHALL ignore start while in SHIFT or DONE; no queuing, no effect on captured operands.
REQ-020 SHALL accept start again in the first IDLE cycle after DONE (back-to-back throughput WIDTH+2 cycles).
REQ-021 SHALL hold sum and cout stable from DONE until the next accepted start; sum/cout internal updates during SHIFT are permitted but SHALL not be treated as valid.
REQ-022 SHALL size the counter to ceil(log2(WIDTH)) bits with no wrap beyond WIDTH-1.
REQ-023 SHALL produce result modulo 2^WIDTH; overflow reported only via cout.

Reset
REQ-024 SHALL, on rst=1, immediately and asynchronously force: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, opA=0, opB=0.
REQ-025 SHALL abort any operation in progress on reset with no partial result retained.
REQ-026 SHALL ignore start while rst=1; first acceptance on the first edge after rst deasserts.

Structure
REQ-027 SHALL place state encoding (IDLE/SHIFT/DONE) and default WIDTH constant in shared package serial_adder_pkg.
REQ-028 SHALL instantiate exactly one existing full_adder sub-module (a, b, cin -> sum, carry) for all bit arithmetic; no "+" operator on operands.
REQ-029 SHALL keep FSM, counter and shift registers in serial_adder_ctrl; no other sub-modules.

Verification (WIDTH=8)
REQ-030 SHALL cover: a=8'h35, b=8'h4A, cin=0, op_sub=0, start -> done exactly 9 cycles after start edge, sum=8'h7F, cout=0, busy high 8 cycles.
REQ-031 SHALL cover: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-032 SHALL cover: op_sub=1, a=8'h20, b=8'h10 -> sum=8'h10, cout=1; a=8'h10, b=8'h20 -> sum=8'hF0, cout=0; cin=1 has no effect.
REQ-033 SHALL cover: start re-pulsed with a=8'h00, b=8'h00 during SHIFT of 8'h35+8'h4A -> ignored, result 8'h7F, single done pulse.
REQ-034 SHALL cover: rst asserted between clock edges after 3 SHIFT edges -> busy, sum, cout 0 immediately without a clock edge; next start with 8'h01+8'h02 -> sum=8'h03.
REQ-035 SHALL cover: start held high continuously -> operations accepted every 10 cycles, done one cycle wide each time.
